// File: rtl/multi_timer_ctrl_pkg.sv
// Shared timer definitions: per-channel state encoding, which is also the
// value presented on each channel's status field.
package multi_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } timer_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUNNING/PAUSED/EXPIRED control with a tick-driven
// counter that terminates at limit, either reloading or expiring.
module timer_channel
  import multi_timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       status,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_d;
  logic             done_d;
  logic             terminal;

  // Using >= means a limit lowered below the current count ends the period on
  // the next tick rather than letting the counter wrap.
  assign terminal = (state_q == ST_RUNNING) && tick && (count >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (terminal) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = '0;
              state_d = stop ? ST_PAUSED : ST_RUNNING;
            end else begin
              state_d = ST_EXPIRED;
            end
          end else begin
            // A stop in the same cycle as a tick still lets that tick count.
            if (tick) count_d = count + CNT_W'(1);
            if (stop) state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (start) state_d = ST_RUNNING;
        end
        ST_EXPIRED: begin
          if (start) begin
            state_d = ST_RUNNING;
            count_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign status = state_q;

endmodule

// File: rtl/multi_timer_ctrl.sv
// Bank of NUM_CH independent timer channels sharing one tick strobe; all
// outputs come from channel registers or decode of registered state.
module multi_timer_ctrl
  import multi_timer_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH*CNT_W-1:0] limit,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [2*NUM_CH-1:0]     status,
  output logic [NUM_CH-1:0]       done,
  output logic                    any_running
);

  logic [NUM_CH-1:0] running;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .start       (start[i]),
      .stop        (stop[i]),
      .clear       (clear[i]),
      .auto_reload (auto_reload[i]),
      .limit       (limit[i*CNT_W +: CNT_W]),
      .count       (count[i*CNT_W +: CNT_W]),
      .status      (status[2*i +: 2]),
      .done        (done[i])
    );
    assign running[i] = (status[2*i +: 2] == ST_RUNNING);
  end

  assign any_running = |running;

endmodule
